// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and pipeline stall handshake
//
// Serves MEM-stage loads and stores (byte/half/word, signed/unsigned loads) from an
// internal word array after WAIT_CYCLES wait states. It reports misaligned, out-of-range,
// illegal-size and simultaneous read+write requests through err.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   memread / memwrite   load / store request, held until ready
//   addr, wdata, func3   byte address, store data (low bits), RV32 size/sign code
//   rdata, err           registered load result and error flag, meaningful while ready=1
//   ready                one-cycle response pulse
//   stall                combinational pipeline freeze request
//   rd_count, wr_count   completed error-free load/store counters
//
// Optional feature: define DMEM_STATS_EN to build the saturating counters. When it is
// not defined, both counter outputs are tied to zero.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  func3_q;
    logic        store_q, both_q, ready_q, err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        req, in_idle, go_resp;
    logic [31:0] a_addr, a_wdata, a_word, byte_sh, rdata_d;
    logic [2:0]  a_func3;
    logic        a_store, a_both, a_err, size_ok, mis, oor, mem_we;
    logic [IW-1:0] a_idx;
    logic [15:0] half_sel;
    logic [3:0]  be;
    logic [31:0] st_data;

    assign req     = memread | memwrite;
    assign in_idle = (state_q == S_IDLE);

    // With zero wait states the access completes on the acceptance edge itself, so the
    // live inputs are used; otherwise the copy latched at acceptance is used.
    assign a_addr  = in_idle ? addr     : addr_q;
    assign a_wdata = in_idle ? wdata    : wdata_q;
    assign a_func3 = in_idle ? func3    : func3_q;
    assign a_store = in_idle ? memwrite : store_q;
    assign a_both  = in_idle ? (memread & memwrite) : both_q;

    assign go_resp = (in_idle && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1));

    assign oor   = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign a_idx = a_addr[IW+1:2];

    always_comb begin
        size_ok = 1'b0;
        mis     = 1'b0;
        case (a_func3)
            3'b000: size_ok = 1'b1;
            3'b001: begin size_ok = 1'b1;     mis = a_addr[0];     end
            3'b010: begin size_ok = 1'b1;     mis = |a_addr[1:0];  end
            3'b100: size_ok = !a_store;
            3'b101: begin size_ok = !a_store; mis = a_addr[0];     end
            default: ;
        endcase
    end

    assign a_err = a_both | !size_ok | mis | oor;

    // Load path: select lane, then sign- or zero-extend (func3[2] marks unsigned).
    assign a_word   = mem[a_idx];
    assign byte_sh  = a_word >> {a_addr[1:0], 3'b000};
    assign half_sel = a_addr[1] ? a_word[31:16] : a_word[15:0];

    always_comb begin
        rdata_d = '0;
        if (!a_err && !a_store) begin
            case (a_func3[1:0])
                2'b00:   rdata_d = {{24{~a_func3[2] & byte_sh[7]}}, byte_sh[7:0]};
                2'b01:   rdata_d = {{16{~a_func3[2] & half_sel[15]}}, half_sel};
                default: rdata_d = a_word;
            endcase
        end
    end

    // Store path: replicate the low data bits across lanes and pick lanes by byte enable.
    always_comb begin
        case (a_func3[1:0])
            2'b00: begin
                be      = 4'b0001 << a_addr[1:0];
                st_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be      = a_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{a_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                st_data = a_wdata;
            end
        endcase
    end

    assign mem_we = go_resp & a_store & ~a_err;

    // Storage is never cleared; rst gating drops a store whose RESP edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[a_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            store_q <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        func3_q <= func3;
                        store_q <= memwrite;
                        both_q  <= memread & memwrite;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
            if (go_resp) begin
                ready_q <= 1'b1;
                err_q   <= a_err;
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = (in_idle && req) || (state_q == S_WAIT);

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (go_resp && !a_err) begin
            if (a_store) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
